cpu_phase_ctl: RTL and testbench
================================

Name: cpu_phase_ctl

Overview:
- Synthesizable phase/clock controller that drives the VeriRISC CPU timing interface: cntrl_clk, clk, fetch and alu_clk.
- Derives these from a 16-phase counter on master_clk; one 16-phase cycle is one instruction.
- Adds run/stop, single-step and halt capture, so the CPU can be sequenced from a debug/host interface instead of free-running.
- Sits between the master clock source and the cpu instance.

Parameters:
- ICOUNT_W, 16, width of the retired-instruction counter.

Ports:
- master_clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 = execute instructions continuously.
- step  input  1  single-cycle pulse; execute exactly one instruction when idle.
- clear_halt  input  1  single-cycle pulse; leave HALTED state.
- halt  input  1  halt flag from the CPU.
- cntrl_clk  output  1  controller clock to the CPU.
- clk  output  1  main CPU clock.
- fetch  output  1  fetch-phase indicator.
- alu_clk  output  1  ALU strobe, active low.
- phase  output  4  current phase counter value.
- busy  output  1  1 while in RUN or STEP.
- halted  output  1  1 while in HALTED.
- instr_count  output  ICOUNT_W  retired instructions; saturating.

Behaviour:
- Phase counter (phase): 4 bits.
  - In RUN/STEP it increments every master_clk posedge and wraps 15->0.
  - In IDLE/HALTED it is held at 0.
- Decodes are combinational from phase only:
  - cntrl_clk = ~phase[0]
  - clk = phase[1]
  - fetch = ~phase[3]
  - alu_clk = ~(phase==12)
- Idle levels at phase 0: cntrl_clk=1, clk=0, fetch=1, alu_clk=1.
- Reset (asynchronous, any time including mid-instruction):
  - phase=0, state=IDLE, instr_count=0.
  - busy=0, halted=0; the clock outputs take their idle levels immediately.
- FSM states: IDLE, RUN, STEP, HALTED.
  - IDLE:
    - run=1 -> RUN.
    - Otherwise step=1 -> STEP.
    - run and step both high: run wins; the step is dropped.
    - clear_halt is ignored.
  - RUN:
    - The instruction boundary is the posedge where phase==15 (phase wraps to 0).
    - At each boundary instr_count is incremented.
    - Then, if halt==1 -> HALTED; else if run==0 -> IDLE; else stay in RUN.
    - run dropping or halt rising mid-instruction never truncates the cycle; the current 16 phases always complete.
    - step is ignored.
  - STEP:
    - Runs one full 16-phase cycle.
    - At the boundary, instr_count is incremented, then HALTED if halt==1, else IDLE.
    - run and step are ignored until the boundary.
  - HALTED:
    - phase held at 0, halted=1.
    - clear_halt=1 -> IDLE on the next posedge; run and step are ignored.
    - Exit is also possible via reset.
- halt is sampled only at the phase==15 posedge. A halt that pulses and clears between boundaries is not captured.
- instr_count:
  - Increments by 1 per completed instruction.
  - Saturates at all-ones; no wrap.
- busy is a registered state decode: 1 in RUN/STEP, 0 otherwise. It rises on the posedge that leaves IDLE.
- Latency:
  - From the posedge sampling run=1 in IDLE, phase=1 on the following posedge.
  - So the first instruction ends 16 posedges after the RUN entry edge.

Test Plan:
- Reset: assert reset mid-RUN at phase 9 -> outputs update before the next master_clk edge: phase=0, cntrl_clk=1, clk=0, fetch=1, alu_clk=1, busy=0, halted=0, instr_count=0.
- Single step: one step pulse in IDLE ->
  - busy=1 for exactly 16 master_clk cycles.
  - clk shows 4 rising edges.
  - alu_clk is low for exactly 1 cycle, at phase 12.
  - fetch is low for phases 8-15.
  - instr_count=1; state returns to IDLE with phase=0.
- Run/stop: run=1 for 3 instructions, then run=0 at phase 5 of the 4th -> the 4th completes to phase 15; instr_count=4; IDLE.
- Halt capture:
  - In RUN, raise halt at phase 7 -> the instruction completes, halted=1 after the boundary, phase stays 0, and run=1 has no effect.
  - A clear_halt pulse -> IDLE, halted=0.
- Simultaneous events: run=1 and step=1 in the same IDLE cycle -> RUN. A step pulse during RUN -> ignored. A halt pulse at phase 3 that clears by phase 10 -> not captured.
- Saturation: with ICOUNT_W=2, run for 5 instructions -> instr_count progresses 1,2,3,3,3.

Source files
------------

// File: rtl/cpu_phase_ctl.sv
// Phase/clock controller for the VeriRISC CPU: a 16-phase counter on master_clk
// produces the CPU timing strobes, with run/stop, single-step and halt capture.
module cpu_phase_ctl #(
    parameter int ICOUNT_W = 16
) (
    input  logic                master_clk,
    input  logic                reset,
    input  logic                run,
    input  logic                step,
    input  logic                clear_halt,
    input  logic                halt,
    output logic                cntrl_clk,
    output logic                clk,
    output logic                fetch,
    output logic                alu_clk,
    output logic [3:0]          phase,
    output logic                busy,
    output logic                halted,
    output logic [ICOUNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_HALTED
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            phase_nxt;
    logic [ICOUNT_W-1:0]   count_nxt;
    logic                  active;
    logic                  boundary;

    assign active   = (state == S_RUN) || (state == S_STEP);
    assign boundary = active && (phase == 4'd15);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            phase       <= 4'd0;
            instr_count <= '0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            instr_count <= count_nxt;
        end
    end

    // NOTE: every output of this block is given a default first so no path
    // through the case statement leaves a signal unassigned (no latches).
    always_comb begin
        state_nxt = state;
        phase_nxt = 4'd0;
        count_nxt = instr_count;

        if (active) begin
            phase_nxt = phase + 4'd1;
        end

        // The retiring instruction is counted before the exit decision.
        if (boundary && (instr_count != '1)) begin
            count_nxt = instr_count + ICOUNT_W'(1);
        end

        unique case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_RUN;
                end else if (step) begin
                    state_nxt = S_STEP;
                end
            end
            S_RUN: begin
                if (boundary) begin
                    if (halt) begin
                        state_nxt = S_HALTED;
                    end else if (!run) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_STEP: begin
                if (boundary) begin
                    state_nxt = halt ? S_HALTED : S_IDLE;
                end
            end
            S_HALTED: begin
                if (clear_halt) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Timing strobes decode from phase alone, so reset drives idle levels at once.
    assign cntrl_clk = ~phase[0];
    assign clk       = phase[1];
    assign fetch     = ~phase[3];
    assign alu_clk   = ~(phase == 4'd12);

    assign busy   = active;
    assign halted = (state == S_HALTED);

endmodule

// File: tb/tb_cpu_phase_ctl.sv
// Scoreboard bench for cpu_phase_ctl: expected samples are queued when stimulus
// is applied and compared on each falling edge of master_clk.
module tb_cpu_phase_ctl;

    logic        master_clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic        clear_halt;
    logic        halt;

    logic        cntrl_clk, clk, fetch, alu_clk, busy, halted;
    logic [3:0]  phase;
    logic [15:0] instr_count;

    logic        s_cntrl_clk, s_clk, s_fetch, s_alu_clk, s_busy, s_halted;
    logic [3:0]  s_phase;
    logic [1:0]  s_instr_count;

    cpu_phase_ctl #(.ICOUNT_W(16)) dut (
        .master_clk  (master_clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .clear_halt  (clear_halt),
        .halt        (halt),
        .cntrl_clk   (cntrl_clk),
        .clk         (clk),
        .fetch       (fetch),
        .alu_clk     (alu_clk),
        .phase       (phase),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    cpu_phase_ctl #(.ICOUNT_W(2)) dut_sat (
        .master_clk  (master_clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .clear_halt  (clear_halt),
        .halt        (halt),
        .cntrl_clk   (s_cntrl_clk),
        .clk         (s_clk),
        .fetch       (s_fetch),
        .alu_clk     (s_alu_clk),
        .phase       (s_phase),
        .busy        (s_busy),
        .halted      (s_halted),
        .instr_count (s_instr_count)
    );

    always #5 master_clk = ~master_clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected sample built from the documented phase decodes and state flags.
    function automatic logic [31:0] pack(input int ph, input bit bz, input bit ht, input int cnt);
        logic [3:0] p;
        p = ph[3:0];
        return {cnt[15:0], 6'd0, p, ~p[0], p[1], ~p[3], ~(p == 4'd12), bz, ht};
    endfunction

    function automatic logic [31:0] main_obs();
        return {instr_count, 6'd0, phase, cntrl_clk, clk, fetch, alu_clk, busy, halted};
    endfunction

    function automatic logic [31:0] sat_obs();
        return {14'd0, s_instr_count, 6'd0, s_phase, s_cntrl_clk, s_clk, s_fetch, s_alu_clk,
                s_busy, s_halted};
    endfunction

    task automatic push_exp(input string tag, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] got);
        sb_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic do_reset();
        @(negedge master_clk);
        reset      = 1'b1;
        run        = 1'b0;
        step       = 1'b0;
        clear_halt = 1'b0;
        halt       = 1'b0;
        @(negedge master_clk);
        reset = 1'b0;
    endtask

    initial begin
        int busy_cyc, clk_rises, alu_low, alu_low_ph, fetch_low;
        logic prev_clk;

        reset      = 1'b1;
        run        = 1'b0;
        step       = 1'b0;
        clear_halt = 1'b0;
        halt       = 1'b0;
        @(negedge master_clk);
        @(negedge master_clk);
        reset = 1'b0;

        // Reset state, then an asynchronous reset at phase 9 of the second instruction.
        push_exp("reset_idle", pack(0, 0, 0, 0));
        @(negedge master_clk);
        pop_cmp(main_obs());
        run = 1'b1;
        for (int j = 0; j <= 25; j++) push_exp("rst_run", pack(j % 16, 1, 0, j / 16));
        for (int j = 0; j <= 25; j++) begin
            @(negedge master_clk);
            pop_cmp(main_obs());
        end
        #2;
        reset = 1'b1;
        run   = 1'b0;
        push_exp("async_reset", pack(0, 0, 0, 0));
        #1;
        pop_cmp(main_obs());
        @(negedge master_clk);
        reset = 1'b0;

        // Single step: 16 busy cycles, strobe shapes, then back to IDLE with count 1.
        do_reset();
        step = 1'b1;
        for (int j = 0; j < 16; j++) push_exp("step", pack(j, 1, 0, 0));
        push_exp("step_done", pack(0, 0, 0, 1));
        busy_cyc = 0; clk_rises = 0; alu_low = 0; alu_low_ph = -1; fetch_low = 0;
        prev_clk = clk;
        for (int j = 0; j <= 16; j++) begin
            @(negedge master_clk);
            pop_cmp(main_obs());
            if (busy) busy_cyc++;
            if (clk && !prev_clk) clk_rises++;
            prev_clk = clk;
            if (!alu_clk) begin
                alu_low++;
                alu_low_ph = int'(phase);
            end
            if (!fetch) fetch_low++;
            if (j == 0) step = 1'b0;
        end
        check("step_busy_cycles", 32'(busy_cyc), 32'd16);
        check("step_clk_rises", 32'(clk_rises), 32'd4);
        check("step_alu_low", 32'(alu_low), 32'd1);
        check("step_alu_phase", 32'(alu_low_ph), 32'd12);
        check("step_fetch_low", 32'(fetch_low), 32'd8);

        // Run/stop: run dropped at phase 5 of the 4th instruction, which still completes.
        do_reset();
        run = 1'b1;
        for (int j = 0; j < 64; j++) push_exp("runstop", pack(j % 16, 1, 0, j / 16));
        push_exp("runstop_done", pack(0, 0, 0, 4));
        for (int j = 0; j <= 64; j++) begin
            @(negedge master_clk);
            pop_cmp(main_obs());
            if (j == 53) run = 1'b0;
        end

        // Halt capture at the boundary; run ignored while halted; clear_halt returns to IDLE.
        do_reset();
        run = 1'b1;
        for (int j = 0; j < 16; j++) push_exp("halt_run", pack(j, 1, 0, 0));
        for (int j = 16; j < 20; j++) push_exp("halted", pack(0, 0, 1, 1));
        push_exp("halt_clear", pack(0, 0, 0, 1));
        push_exp("halt_clear_idle", pack(0, 0, 0, 1));
        for (int j = 0; j <= 21; j++) begin
            @(negedge master_clk);
            pop_cmp(main_obs());
            if (j == 7) halt = 1'b1;
            if (j == 19) begin
                clear_halt = 1'b1;
                run        = 1'b0;
                halt       = 1'b0;
            end
            if (j == 20) clear_halt = 1'b0;
        end

        // run+step together -> RUN; step in RUN ignored; short halt pulse not captured.
        do_reset();
        run  = 1'b1;
        step = 1'b1;
        for (int j = 0; j < 48; j++) push_exp("simul", pack(j % 16, 1, 0, j / 16));
        push_exp("simul_done", pack(0, 0, 0, 3));
        push_exp("simul_idle", pack(0, 0, 0, 3));
        for (int j = 0; j <= 49; j++) begin
            @(negedge master_clk);
            pop_cmp(main_obs());
            if (j == 0)  step = 1'b0;
            if (j == 21) step = 1'b1;
            if (j == 22) step = 1'b0;
            if (j == 35) halt = 1'b1;
            if (j == 40) run  = 1'b0;
            if (j == 41) halt = 1'b0;
        end

        // Saturation on the 2-bit counter instance: 1,2,3,3,3.
        do_reset();
        run = 1'b1;
        for (int j = 0; j <= 80; j++) begin
            if (j < 80) push_exp("sat_main", pack(j % 16, 1, 0, j / 16));
            else        push_exp("sat_main_done", pack(0, 0, 0, 5));
            if (j > 0 && j % 16 == 0)
                push_exp("sat_count", pack(0, (j < 80), 0, (j / 16 > 3) ? 3 : j / 16));
        end
        for (int j = 0; j <= 80; j++) begin
            @(negedge master_clk);
            pop_cmp(main_obs());
            if (j > 0 && j % 16 == 0) pop_cmp(sat_obs());
            if (j == 70) run = 1'b0;
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
